// File: rtl/mux_n_1_reg.sv
// rtl/mux_n_1_reg.sv - registered N:1 channel mux behind a two-entry skid buffer
//
// Purpose:
//   On each accepted input beat, picks channel[sel] out of the packed input
//   bus. If sel names a channel that does not exist, it stores
//   {data = 0, err = 1} instead. The entry then goes into a two-register
//   (main + skid) buffer. The consumer always sees the head entry from the
//   main register. in_ready depends only on the registered state, so there
//   is no combinational path from out_ready back to in_ready.
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - synchronous active-high reset (beats flush, accept and pop)
//   flush     - synchronous discard of every buffered entry and of any beat
//               accepted in the same cycle
//   sel       - channel index, sampled together with the input beat
//   in_data   - N packed channels, channel k = in_data[k*WIDTH +: WIDTH]
//   in_valid  - input beat present
//   in_ready  - block can take a beat (EMPTY or ONE)
//   out_data  - selected channel of the head entry
//   out_err   - head entry was captured with sel >= N
//   out_valid - head entry present (ONE or FULL)
//   out_ready - consumer takes the head entry

module mux_n_1_reg #(
    parameter int WIDTH = 5,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [SELW-1:0]      sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_err,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             main_err_q,  main_err_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_err_q,  skid_err_d;

    logic             accept;
    logic             pop;
    logic [WIDTH-1:0] new_data;
    logic             new_err;

    // Handshake flags come only from registered state.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_data_q;
    assign out_err   = main_err_q;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    // Channel select. The loop checks every real channel index. If none
    // matches, sel is out of range and the entry is flagged as an error
    // with zero data.
    always_comb begin
        new_data = '0;
        new_err  = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (sel == SELW'(k)) begin
                new_data = in_data[k*WIDTH +: WIDTH];
                new_err  = 1'b0;
            end
        end
    end

    // Next-state and next-entry logic.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;

        if (flush) begin
            // Flush drops both entries and any same-cycle accept. A pop in
            // the same cycle is not a delivery.
            state_d     = ST_EMPTY;
            main_data_d = '0;
            main_err_d  = 1'b0;
            skid_data_d = '0;
            skid_err_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_ONE;
                        main_data_d = new_data;
                        main_err_d  = new_err;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_data_d = new_data;
                        main_err_d  = new_err;
                    end else if (accept) begin
                        // The head stays put so the consumer sees stable
                        // data. The newcomer waits in skid.
                        state_d     = ST_FULL;
                        skid_data_d = new_data;
                        skid_err_d  = new_err;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a pop can move state.
                    if (pop) begin
                        state_d     = ST_ONE;
                        main_data_d = skid_data_q;
                        main_err_d  = skid_err_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
        end
    end

endmodule

// File: tb/tb_mux_n_1_reg.sv
// tb/tb_mux_n_1_reg.sv - self-checking bench for mux_n_1_reg against a queue model

module tb_mux_n_1_reg;

    localparam int WIDTH = 5;
    localparam int N     = 4;
    localparam int SELW  = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic [SELW-1:0]      sel;
    logic [N*WIDTH-1:0]   in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_err;
    logic                 out_valid;
    logic                 out_ready;

    int tests_run = 0;
    int tests_failed = 0;
    bit checking = 1'b0;

    // Each model entry is {err, data}. The buffer holds up to two entries.
    logic [WIDTH:0] model_q[$];

    localparam logic [N*WIDTH-1:0] CHANNELS = {5'h1F, 5'h15, 5'h0A, 5'h01};

    mux_n_1_reg #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH:0] entry_of(input logic [N*WIDTH-1:0] d, input int s);
        if (s < N) return {1'b0, d[s*WIDTH +: WIDTH]};
        return {1'b1, {WIDTH{1'b0}}};
    endfunction

    // Behavioural model. The buffer is an ordered queue of at most two
    // entries. Reset and flush empty it. Otherwise the head leaves if the
    // consumer is ready, and a beat enters if there was room before the edge.
    always @(posedge clk) begin
        bit acc;
        bit pp;
        if (rst || flush) begin
            model_q.delete();
        end else begin
            acc = in_valid && (model_q.size() < 2);
            pp  = (model_q.size() > 0) && out_ready;
            if (pp) void'(model_q.pop_front());
            if (acc) model_q.push_back(entry_of(in_data, int'(sel)));
        end
    end

    // Per-cycle compare. DUT outputs are registered, so the negedge is a
    // stable sampling point.
    always @(negedge clk) begin
        if (checking) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, model_q.size() < 2});
            check("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() > 0});
            if (model_q.size() > 0) begin
                check("out_data", {27'd0, out_data}, {27'd0, model_q[0][WIDTH-1:0]});
                check("out_err", {31'd0, out_err}, {31'd0, model_q[0][WIDTH]});
            end
        end
    end

    // Apply one cycle of inputs: change at negedge, then the DUT samples
    // them at the next posedge, and control returns at the following negedge.
    task automatic drive(input bit v, input int s, input bit ordy, input bit fl, input bit r);
        in_valid  = v;
        sel       = SELW'(s);
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [5:0] vld_rdy_err_x,
                       input logic [WIDTH-1:0] data);
        // vld_rdy_err_x = {out_valid, in_ready, out_err, check_data, 2'b0}
        check({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, vld_rdy_err_x[5]});
        check({name, ".in_ready"},  {31'd0, in_ready},  {31'd0, vld_rdy_err_x[4]});
        if (vld_rdy_err_x[2]) begin
            check({name, ".out_err"},  {31'd0, out_err},  {31'd0, vld_rdy_err_x[3]});
            check({name, ".out_data"}, {27'd0, out_data}, {27'd0, data});
        end
    endtask

    initial begin
        in_data   = CHANNELS;
        in_valid  = 1'b0;
        sel       = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        drive(0, 0, 0, 0, 1);
        checking = 1'b1;

        // Reset state.
        lit("reset", 6'b010100, 5'h00);

        // Single beat: latency one cycle.
        drive(1, 2, 1, 0, 0);
        lit("sel2", 6'b110100, 5'h15);
        drive(0, 0, 1, 0, 0);
        lit("drain1", 6'b010000, 5'h00);

        // Fill to FULL with out_ready low, then drain in order.
        drive(1, 1, 0, 0, 0);
        drive(1, 3, 0, 0, 0);
        lit("full", 6'b100100, 5'h0A);
        drive(1, 0, 0, 0, 0);
        lit("full_hold", 6'b100100, 5'h0A);
        drive(0, 0, 1, 0, 0);
        lit("full_pop", 6'b110100, 5'h1F);
        drive(0, 0, 1, 0, 0);
        lit("full_empty", 6'b010000, 5'h00);

        // Out-of-range select followed by a valid select.
        drive(1, 5, 0, 0, 0);
        lit("sel5", 6'b111100, 5'h00);
        drive(1, 0, 1, 0, 0);
        lit("sel0", 6'b110100, 5'h01);
        drive(0, 0, 1, 0, 0);

        // Streaming at full rate.
        for (int i = 0; i < 4; i++) begin
            logic [N*WIDTH-1:0] ch;
            ch = CHANNELS;
            drive(1, i, 1, 0, 0);
            lit("stream", 6'b110100, ch[i*WIDTH +: WIDTH]);
        end
        drive(0, 0, 1, 0, 0);
        lit("stream_end", 6'b010000, 5'h00);

        // Flush from FULL while a beat is offered.
        drive(1, 1, 0, 0, 0);
        drive(1, 3, 0, 0, 0);
        drive(1, 2, 1, 1, 0);
        lit("flush", 6'b010000, 5'h00);
        drive(0, 0, 1, 0, 0);
        lit("flush_after", 6'b010000, 5'h00);

        // Reset from ONE while a beat is offered.
        drive(1, 1, 0, 0, 0);
        drive(1, 2, 0, 0, 1);
        lit("rst_mid", 6'b010100, 5'h00);
        drive(0, 0, 1, 0, 0);
        lit("rst_after", 6'b010000, 5'h00);
        drive(1, 3, 0, 0, 0);
        lit("post_rst_accept", 6'b110100, 5'h1F);
        drive(0, 0, 1, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            in_data = N*WIDTH'($urandom);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 99) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
